l2_norm_driver: RTL and testbench

Initiator-side sequencer for the L2-norm datapath. Holds a vector of up to `DEPTH` unsigned bytes in a local buffer and, on `start`, clears the downstream squaring accumulator. It then streams the vector one byte per cycle and counts the norm unit's result strobes. It captures the final 10-bit root as the vector norm and flags `done`. It sits between the host/test harness and the norm unit, driving the unit's byte input, valid input and synchronous clear.

---
 rtl/l2_norm_driver_if.sv | 13 +
 rtl/l2_norm_driver.sv | 204 ++++++++++++++++++++
 tb/tb_l2_norm_driver.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/l2_norm_driver_if.sv
// Link between the L2-norm sequencer and the norm unit it feeds.
// The master side (the sequencer) drives bytes and the accumulator clear.
// The slave side (the norm unit) returns the running root and its strobe.
interface l2_norm_driver_if;
  logic       acc_clr;
  logic [7:0] a_out;
  logic       a_valid;
  logic [9:0] g_in;
  logic       g_valid;

  modport master (output acc_clr, a_out, a_valid, input g_in, g_valid);
  modport slave  (input acc_clr, a_out, a_valid, output g_in, g_valid);
endinterface

// File: rtl/l2_norm_driver.sv
// l2_norm_driver: initiator-side sequencer for the L2-norm datapath.
// Holds a byte vector in a local buffer. On start it clears the norm unit's
// accumulator, streams the vector one byte per cycle, and counts the result
// strobes. It then captures the final root and pulses done.
// Optional feature: define L2_DRV_TIMEOUT_EN to add a DRAIN watchdog. The
// watchdog aborts with an err pulse after TIMEOUT strobe-free cycles.
module l2_norm_driver #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 32,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  input  logic [LW-1:0] len_i,
  input  logic          start_i,
  output logic          busy_o,
  output logic [9:0]    norm_o,
  output logic          done_o,
  output logic          err_o,
  l2_norm_driver_if.master nu
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] ONE_L   = LW'(1);

  // Catch unusable parameterisations at elaboration time.
  if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
    $error("l2_norm_driver: illegal DEPTH/TIMEOUT");
  end

  // A launch length is legal when 1 <= len <= DEPTH.
  function automatic logic len_ok(input logic [LW-1:0] l);
    return (l != {LW{1'b0}}) && (l <= DEPTH_L);
  endfunction

  logic [7:0]    mem_q [DEPTH];
  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] idx_q, idx_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic          acc_clr_q, acc_clr_d;
  logic [7:0]    a_out_q, a_out_d;
  logic          a_valid_q, a_valid_d;
  logic          busy_q, busy_d;
  logic [9:0]    norm_q, norm_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
`ifdef L2_DRV_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_q, wd_d;
`endif

  // Buffer write port; the buffer is locked while a run is in flight.
  always_ff @(posedge clk) begin
    if (wr_en_i && !busy_q) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Next-state and registered-output logic for the sequencer.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    acc_clr_d = 1'b0;
    a_out_d   = 8'd0;
    a_valid_d = 1'b0;
    norm_d    = norm_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
`ifdef L2_DRV_TIMEOUT_EN
    wd_d      = wd_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_ok(len_i)) begin
            len_d     = len_i;
            cnt_d     = {LW{1'b0}};
            acc_clr_d = 1'b1;
            state_d   = S_CLEAR;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        // First byte is issued directly so there is no bubble after the clear.
        a_valid_d = 1'b1;
        a_out_d   = mem_q[0];
        idx_d     = ONE_L;
        state_d   = S_STREAM;
      end
      S_STREAM: begin
        if (nu.g_valid) begin
          cnt_d = cnt_q + ONE_L;
        end else begin
          cnt_d = cnt_q;
        end
        if (idx_q == len_q) begin
          state_d = S_DRAIN;
`ifdef L2_DRV_TIMEOUT_EN
          wd_d    = {WW{1'b0}};
`endif
        end else begin
          a_valid_d = 1'b1;
          a_out_d   = mem_q[idx_q[AW-1:0]];
          idx_d     = idx_q + ONE_L;
        end
      end
      S_DRAIN: begin
        if (nu.g_valid) begin
`ifdef L2_DRV_TIMEOUT_EN
          wd_d = {WW{1'b0}};
`endif
          if ((cnt_q + ONE_L) == len_q) begin
            norm_d  = nu.g_in;
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + ONE_L;
          end
        end else begin
`ifdef L2_DRV_TIMEOUT_EN
          if (wd_q == WW'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            wd_d = wd_q + {{(WW-1){1'b0}}, 1'b1};
          end
`else
          state_d = S_DRAIN;
`endif
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; async reset drops every output at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      len_q     <= {LW{1'b0}};
      idx_q     <= {LW{1'b0}};
      cnt_q     <= {LW{1'b0}};
      acc_clr_q <= 1'b0;
      a_out_q   <= 8'd0;
      a_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      norm_q    <= 10'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef L2_DRV_TIMEOUT_EN
      wd_q      <= {WW{1'b0}};
`endif
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      acc_clr_q <= acc_clr_d;
      a_out_q   <= a_out_d;
      a_valid_q <= a_valid_d;
      busy_q    <= busy_d;
      norm_q    <= norm_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef L2_DRV_TIMEOUT_EN
      wd_q      <= wd_d;
`endif
    end
  end

  assign nu.acc_clr = acc_clr_q;
  assign nu.a_out   = a_out_q;
  assign nu.a_valid = a_valid_q;
  assign busy_o     = busy_q;
  assign norm_o     = norm_q;
  assign done_o     = done_q;
  assign err_o      = err_q;

endmodule

// File: tb/tb_l2_norm_driver.sv
// Self-checking bench for l2_norm_driver with a behavioural norm-unit model.
// The model squares and accumulates bytes and returns floor(sqrt) 3 cycles later.
module tb_l2_norm_driver;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [4:0] len;
  logic       start;
  logic       busy, done, err;
  logic [9:0] norm;
  int         checks = 0;
  int         errors = 0;
  bit         suppress = 1'b0;

  always #5 clk = ~clk;

  l2_norm_driver_if nif();

  l2_norm_driver #(.DEPTH(16), .TIMEOUT(32)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .len_i(len), .start_i(start), .busy_o(busy),
    .norm_o(norm), .done_o(done), .err_o(err), .nu(nif)
  );

  // ---- norm unit model ----
  function automatic logic [9:0] isqrt(input logic [19:0] x);
    logic [9:0] r;
    r = 10'd0;
    for (int i = 1; i < 1024; i++) if (i * i <= int'(x)) r = 10'(i);
    return r;
  endfunction

  logic [19:0] sum_m, ns_m;
  logic [9:0]  root_m, pr0, pr1, pr2;
  logic [2:0]  pv;
  assign ns_m   = sum_m + 20'(nif.a_out) * 20'(nif.a_out);
  assign root_m = isqrt(ns_m);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sum_m <= 20'd0; pv <= 3'd0; pr0 <= 10'd0; pr1 <= 10'd0; pr2 <= 10'd0;
    end else begin
      if (nif.acc_clr) sum_m <= 20'd0;
      else if (nif.a_valid) sum_m <= ns_m;
      pv  <= {pv[1:0], nif.a_valid & ~suppress};
      pr0 <= root_m; pr1 <= pr0; pr2 <= pr1;
    end
  end
  assign nif.g_valid = pv[2];
  assign nif.g_in    = pr2;

  // ---- helpers ----
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic write_buf(input logic [127:0] data);
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = data[8*i +: 8];
      step();
    end
    wr_en = 1'b0;
  endtask

  // Launch a run and check every cycle t+1 .. t+len+6 against the timing rules.
  task automatic run_vec(input string nm, input logic [4:0] l, input logic [127:0] data,
                         input logic [9:0] exp_norm, input bit load);
    logic [127:0] sh;
    logic [12:0]  obs, exp;
    int           n;
    if (load) write_buf(data);
    n = int'(l);
    len = l; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= n + 6; k++) begin
      sh  = data >> (8 * (k - 2));
      exp = {1'(k <= n + 5), 1'(k == 1), 1'(k >= 2 && k <= n + 1), 1'(k == n + 5), 1'b0,
             ((k >= 2 && k <= n + 1) ? sh[7:0] : 8'h00)};
      obs = {busy, nif.acc_clr, nif.a_valid, done, err, (nif.a_valid ? nif.a_out : 8'h00)};
      check($sformatf("%s_cyc%0d", nm, k), 32'(obs), 32'(exp));
      if (k == n + 5) check($sformatf("%s_norm", nm), 32'(norm), 32'(exp_norm));
      if (k == n + 6) check($sformatf("%s_norm_hold", nm), 32'(norm), 32'(exp_norm));
      step();
    end
  endtask

  typedef struct packed {
    logic [4:0]   len;
    logic [127:0] data;
    logic [9:0]   norm;
  } vec_t;
  vec_t vecs [7];

  initial begin
    vecs[0] = '{len: 5'd2,  data: {112'd0, 8'd4, 8'd3},        norm: 10'd5};
    vecs[1] = '{len: 5'd16, data: {16{8'd255}},                norm: 10'd1020};
    vecs[2] = '{len: 5'd1,  data: {120'd0, 8'd7},              norm: 10'd7};
    vecs[3] = '{len: 5'd3,  data: {104'd0, 8'd2, 8'd2, 8'd1},  norm: 10'd3};
    vecs[4] = '{len: 5'd4,  data: {96'd0, {4{8'd10}}},         norm: 10'd20};
    vecs[5] = '{len: 5'd5,  data: {88'd0, {5{8'd1}}},          norm: 10'd2};
    vecs[6] = '{len: 5'd8,  data: {64'd0, {8{8'd200}}},        norm: 10'd565};

    reset_n = 1'b0; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'd0; len = 5'd0; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", 32'({busy, done, err, nif.acc_clr, nif.a_valid}), 32'd0);
    check("reset_norm", 32'(norm), 32'd0);
    reset_n = 1'b1;
    step();

    // Table-driven runs
    for (int i = 0; i < 7; i++)
      run_vec($sformatf("vec%0d", i), vecs[i].len, vecs[i].data, vecs[i].norm, 1'b1);

    // Illegal lengths: err for one cycle, nothing launched
    for (int i = 0; i < 2; i++) begin
      len = (i == 0) ? 5'd0 : 5'd17; start = 1'b1;
      step();
      start = 1'b0;
      check($sformatf("badlen%0d_t1", i), 32'({err, busy, nif.acc_clr, nif.a_valid}), 32'b1000);
      step();
      check($sformatf("badlen%0d_t2", i), 32'({err, busy, nif.acc_clr, nif.a_valid}), 32'b0000);
    end

    // start and write during STREAM are ignored/dropped
    write_buf({112'd0, 8'd2, 8'd17});
    len = 5'd2; start = 1'b1;
    step();                                    // cycle t+1
    start = 1'b0;
    step();                                    // cycle t+2
    start = 1'b1; len = 5'd1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'hAA;
    step();                                    // cycle t+3
    start = 1'b0; wr_en = 1'b0;
    check("busy_stream_b2", 32'({busy, nif.a_valid, nif.a_out}), 32'({1'b1, 1'b1, 8'd2}));
    repeat (4) step();                         // cycle t+7
    check("busy_ign_done", 32'(done), 32'd1);
    check("busy_ign_norm", 32'(norm), 32'd17);
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("busy_ign_idle%0d", k), 32'({busy, done, nif.acc_clr}), 32'd0);
    end
    run_vec("old_buf0", 5'd1, {120'd0, 8'd17}, 10'd17, 1'b0);

    // Back-to-back: start during DONE ignored, accepted next cycle
    write_buf({120'd0, 8'd7});
    len = 5'd1; start = 1'b1;
    step();                                    // t+1
    start = 1'b0;
    repeat (5) step();                         // t+6
    check("b2b_done", 32'({done, norm}), 32'({1'b1, 10'd7}));
    start = 1'b1;
    step();                                    // t+7
    check("b2b_idle", 32'({busy, nif.acc_clr}), 32'd0);
    step();                                    // t+8
    start = 1'b0;
    check("b2b_relaunch", 32'({busy, nif.acc_clr}), 32'b11);
    repeat (5) step();                         // t+13
    check("b2b_done2", 32'({done, norm}), 32'({1'b1, 10'd7}));

    // Asynchronous reset during the third streamed byte
    write_buf({96'd0, 8'd4, 8'd3, 8'd2, 8'd1});
    len = 5'd4; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();                         // t+4: third byte
    check("rst_pre", 32'({nif.a_valid, nif.a_out}), 32'({1'b1, 8'd3}));
    #2 reset_n = 1'b0;
    #1;
    check("rst_now", 32'({nif.a_valid, busy, nif.acc_clr, norm}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check($sformatf("rst_quiet%0d", k), 32'({busy, done, err}), 32'd0);
    end
    run_vec("rst_run", 5'd1, {120'd0, 8'd7}, 10'd7, 1'b1);

`ifdef L2_DRV_TIMEOUT_EN
    // Watchdog: no strobes at all -> err 32 cycles after DRAIN entry
    write_buf({96'd0, {4{8'd5}}});
    suppress = 1'b1;
    len = 5'd4; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      check($sformatf("wd_cyc%0d", k), 32'({busy, done, err}),
            32'({1'(k <= 37), 1'b0, 1'(k == 38)}));
      step();
    end
    suppress = 1'b0;
    run_vec("wd_after", 5'd4, {96'd0, {4{8'd5}}}, 10'd10, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
